fast_pkt_read_sched: RTL and testbench

- Sequencer for the fast capture-buffer readout path: reads captured ADC words out of the bank-interleaved SRAM array (up to 24 banks, 15-bit address each).
- Frames the words into fixed-length packets separated by idle gaps.
- Drives the SRAM chip enables and shared address, realigns returned read data, and presents an 18-bit ADC_DATA/ADC_DATA_VALID stream to the packet/output stage.
- Pulses fast_rd_done when the programmed capture length has been drained.

---
 rtl/fast_pkt_read_sched.sv | 170 +++++++++++++++++
 tb/tb_fast_pkt_read_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_pkt_read_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fast_pkt_read_sched : packetised bank-interleaved SRAM readout sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module fast_pkt_read_sched #(
    parameter int NUM_BANK = 24,
    parameter int RD_LAT   = 1,
    parameter int DW       = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rf_96path_en,
    input  logic [1:0]             rf_pkt_data_length,
    input  logic [1:0]             rf_pkt_idle_length,
    input  logic [19:0]            rf_total_words,
    input  logic                   fast_read_en,
    output logic [NUM_BANK-1:0]    fast_chip_en,
    output logic [14:0]            fast_addr,
    input  logic [NUM_BANK*DW-1:0] fast_rdata,
    output logic                   fast_rd_done,
    output logic                   fast_busy,
    output logic [DW-1:0]          ADC_DATA,
    output logic                   ADC_DATA_VALID
);
    localparam int              BW             = $clog2(NUM_BANK);
    localparam logic [19:0]     MAX_WORDS_FULL = 20'(NUM_BANK * 32768);
    localparam logic [19:0]     MAX_WORDS_HALF = 20'((NUM_BANK / 2) * 32768);
    localparam logic [BW-1:0]   LAST_BANK_FULL = BW'(NUM_BANK - 1);
    localparam logic [BW-1:0]   LAST_BANK_HALF = BW'(NUM_BANK / 2 - 1);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        DATA  = 5'b00010,
        GAP   = 5'b00100,
        DRAIN = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t         state;
    logic [BW-1:0]  last_bank;
    logic [9:0]     plen;
    logic [5:0]     ilen;
    logic [19:0]    total;
    logic [19:0]    wcnt;
    logic [9:0]     pcnt;
    logic [5:0]     icnt;
    logic [1:0]     dcnt;
    logic [BW-1:0]  bank;
    logic [14:0]    row;
    logic [BW-1:0]  ce_bank;
    logic [19:0]    max_words;
    logic [19:0]    total_clamped;

    always_comb begin
        max_words     = rf_96path_en ? MAX_WORDS_FULL : MAX_WORDS_HALF;
        total_clamped = (rf_total_words > max_words) ? max_words : rf_total_words;
    end

    // Outputs are registered from the state/counters, so every output trails the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_bank    <= '0;
            plen         <= '0;
            ilen         <= '0;
            total        <= '0;
            wcnt         <= '0;
            pcnt         <= '0;
            icnt         <= '0;
            dcnt         <= '0;
            bank         <= '0;
            row          <= '0;
            ce_bank      <= '0;
            fast_chip_en <= '0;
            fast_addr    <= '0;
            fast_rd_done <= 1'b0;
            fast_busy    <= 1'b0;
        end else begin
            fast_chip_en <= (state == DATA) ? (NUM_BANK'(1) << bank) : '0;
            ce_bank      <= bank;
            if (state == DATA)
                fast_addr <= row;
            fast_rd_done <= (state == DONE);
            fast_busy    <= (state != IDLE);

            case (state)
                IDLE: begin
                    if (fast_read_en) begin
                        last_bank <= rf_96path_en ? LAST_BANK_FULL : LAST_BANK_HALF;
                        plen      <= 10'd96 << rf_pkt_data_length;
                        ilen      <= 6'd4 << rf_pkt_idle_length;
                        total     <= total_clamped;
                        wcnt      <= '0;
                        pcnt      <= '0;
                        bank      <= '0;
                        row       <= '0;
                        state     <= (rf_total_words != 20'd0) ? DATA : DONE;
                    end
                end
                DATA: begin
                    wcnt <= wcnt + 20'd1;
                    pcnt <= pcnt + 10'd1;
                    if (bank == last_bank) begin
                        bank <= '0;
                        row  <= row + 15'd1;
                    end else begin
                        bank <= bank + BW'(1);
                    end
                    // End of run wins over end of packet, so the last packet may be short.
                    if (wcnt == total - 20'd1) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else if (pcnt == plen - 10'd1) begin
                        state <= GAP;
                        pcnt  <= '0;
                        icnt  <= '0;
                    end
                end
                GAP: begin
                    icnt <= icnt + 6'd1;
                    if (icnt == ilen - 6'd1)
                        state <= DATA;
                end
                DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'(RD_LAT - 1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic           pv  [RD_LAT];
    logic [BW-1:0]  pb  [RD_LAT];
    logic [DW-1:0]  sel_word;

    always_comb begin
        sel_word = '0;
        for (int b = 0; b < NUM_BANK; b++)
            if (pb[RD_LAT-1] == BW'(b))
                sel_word = fast_rdata[b*DW +: DW];
    end

    // Bank index and read flag travel with the read so returning data can be picked out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pb[i] <= '0;
            end
            ADC_DATA       <= '0;
            ADC_DATA_VALID <= 1'b0;
        end else begin
            pv[0] <= |fast_chip_en;
            pb[0] <= ce_bank;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pb[i] <= pb[i-1];
            end
            ADC_DATA_VALID <= pv[RD_LAT-1];
            if (pv[RD_LAT-1])
                ADC_DATA <= sel_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fast_pkt_read_sched.sv
`default_nettype none
// Bench: two DUTs (RD_LAT=1 and RD_LAT=3) share stimulus; a behavioural model
// expands each run into its expected bank/address, packet and data sequence.
module tb_fast_pkt_read_sched;
    localparam int NUM_BANK = 24;
    localparam int DW       = 18;

    logic        clk                = 1'b0;
    logic        rst                = 1'b1;
    logic        rf_96path_en       = 1'b1;
    logic [1:0]  rf_pkt_data_length = '0;
    logic [1:0]  rf_pkt_idle_length = '0;
    logic [19:0] rf_total_words     = '0;
    logic        fast_read_en       = 1'b0;

    logic [NUM_BANK-1:0]    ce_a, ce_b;
    logic [14:0]            addr_a, addr_b;
    logic [NUM_BANK*DW-1:0] rdata_a, rdata_b;
    logic                   done_a, done_b, busy_a, busy_b, vld_a, vld_b;
    logic [DW-1:0]          data_a, data_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fast_pkt_read_sched #(.NUM_BANK(NUM_BANK), .RD_LAT(1), .DW(DW)) dut_a (
        .clk(clk), .rst(rst), .rf_96path_en(rf_96path_en),
        .rf_pkt_data_length(rf_pkt_data_length), .rf_pkt_idle_length(rf_pkt_idle_length),
        .rf_total_words(rf_total_words), .fast_read_en(fast_read_en),
        .fast_chip_en(ce_a), .fast_addr(addr_a), .fast_rdata(rdata_a),
        .fast_rd_done(done_a), .fast_busy(busy_a), .ADC_DATA(data_a), .ADC_DATA_VALID(vld_a));

    fast_pkt_read_sched #(.NUM_BANK(NUM_BANK), .RD_LAT(3), .DW(DW)) dut_b (
        .clk(clk), .rst(rst), .rf_96path_en(rf_96path_en),
        .rf_pkt_data_length(rf_pkt_data_length), .rf_pkt_idle_length(rf_pkt_idle_length),
        .rf_total_words(rf_total_words), .fast_read_en(fast_read_en),
        .fast_chip_en(ce_b), .fast_addr(addr_b), .fast_rdata(rdata_b),
        .fast_rd_done(done_b), .fast_busy(busy_b), .ADC_DATA(data_b), .ADC_DATA_VALID(vld_b));

    // SRAM bank models: an enabled bank returns {addr[12:0], bank}, others return junk.
    logic [NUM_BANK-1:0] hce_a = '0;
    logic [14:0]         haddr_a = '0;
    logic [NUM_BANK-1:0] hce_b [3];
    logic [14:0]         haddr_b [3];
    always @(posedge clk) begin
        hce_a      <= ce_a;
        haddr_a    <= addr_a;
        hce_b[0]   <= ce_b;
        haddr_b[0] <= addr_b;
        for (int i = 1; i < 3; i++) begin
            hce_b[i]   <= hce_b[i-1];
            haddr_b[i] <= haddr_b[i-1];
        end
    end
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            rdata_a[b*DW +: DW] = (hce_a[b] === 1'b1)    ? {haddr_a[12:0], 5'(b)}    : (18'h2AAAA ^ 18'(b));
            rdata_b[b*DW +: DW] = (hce_b[2][b] === 1'b1) ? {haddr_b[2][12:0], 5'(b)} : (18'h15555 ^ 18'(b));
        end
    end

    // Monitor
    logic          mon_clr = 1'b0;
    int            ce_bank_q[$];
    int            ce_addr_q[$];
    logic [DW-1:0] dq_a[$];
    logic [DW-1:0] dq_b[$];
    int            burst_q[$];
    int            gap_q[$];
    int            run_len, gap_len, nbursts;
    bit            in_burst;
    int            mh_a, done_cnt_a, done_cyc_a, first_ce_a, last_ce_a, first_vld_a;
    int            first_ce_b, first_vld_b, done_cnt_b;

    function automatic int low_bit(input logic [NUM_BANK-1:0] v);
        for (int i = 0; i < NUM_BANK; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_clr) begin
            ce_bank_q.delete(); ce_addr_q.delete(); dq_a.delete(); dq_b.delete();
            burst_q.delete(); gap_q.delete();
            run_len = 0; gap_len = 0; nbursts = 0; in_burst = 1'b0;
            mh_a = 0; done_cnt_a = 0; done_cyc_a = -1; first_ce_a = -1; last_ce_a = -1;
            first_vld_a = -1; first_ce_b = -1; first_vld_b = -1; done_cnt_b = 0;
        end else begin
            if (ce_a != '0) begin
                if (!$onehot(ce_a)) mh_a++;
                ce_bank_q.push_back(low_bit(ce_a));
                ce_addr_q.push_back(int'(addr_a));
                if (first_ce_a < 0) first_ce_a = cyc;
                last_ce_a = cyc;
            end
            if (vld_a) begin
                dq_a.push_back(data_a);
                if (first_vld_a < 0) first_vld_a = cyc;
                if (!in_burst) begin
                    if (nbursts > 0) gap_q.push_back(gap_len);
                    run_len  = 0;
                    in_burst = 1'b1;
                end
                run_len++;
            end else begin
                if (in_burst) begin
                    burst_q.push_back(run_len);
                    in_burst = 1'b0;
                    gap_len  = 0;
                    nbursts++;
                end
                gap_len++;
            end
            if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (ce_b != '0 && first_ce_b < 0) first_ce_b = cyc;
            if (vld_b) begin
                dq_b.push_back(data_b);
                if (first_vld_b < 0) first_vld_b = cyc;
            end
            if (done_b) done_cnt_b++;
        end
    end

    // Reference model
    int exp_bank[$];
    int exp_addr[$];
    int exp_burst[$];
    int m_ilen;

    task automatic model_run(input int total, input int lc, input int ic, input bit en96);
        int nb, plen, t, rem;
        nb   = en96 ? NUM_BANK : NUM_BANK / 2;
        plen = 96 * (1 << lc);
        t    = (total > nb * 32768) ? nb * 32768 : total;
        m_ilen = 4 * (1 << ic);
        exp_bank.delete(); exp_addr.delete(); exp_burst.delete();
        for (int w = 0; w < t; w++) begin
            exp_bank.push_back(w % nb);
            exp_addr.push_back((w / nb) % 32768);
        end
        rem = t;
        while (rem > 0) begin
            exp_burst.push_back(rem < plen ? rem : plen);
            rem -= plen;
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int i);
        logic [14:0] a;
        logic [4:0]  b;
        a = 15'(exp_addr[i]);
        b = 5'(exp_bank[i]);
        return {a[12:0], b};
    endfunction

    function automatic int ce_mism();
        int n = 0;
        if (ce_bank_q.size() != exp_bank.size()) n++;
        for (int i = 0; i < ce_bank_q.size() && i < exp_bank.size(); i++)
            if (ce_bank_q[i] != exp_bank[i] || ce_addr_q[i] != exp_addr[i]) n++;
        return n;
    endfunction

    function automatic int data_mism(input bit use_b);
        int n = 0;
        int sz;
        sz = use_b ? dq_b.size() : dq_a.size();
        if (sz != exp_bank.size()) n++;
        for (int i = 0; i < sz && i < exp_bank.size(); i++)
            if ((use_b ? dq_b[i] : dq_a[i]) !== exp_word(i)) n++;
        return n;
    endfunction

    function automatic int burst_mism();
        int n = 0;
        if (burst_q.size() != exp_burst.size()) n++;
        for (int i = 0; i < burst_q.size() && i < exp_burst.size(); i++)
            if (burst_q[i] != exp_burst[i]) n++;
        if (exp_burst.size() > 0 && gap_q.size() != exp_burst.size() - 1) n++;
        foreach (gap_q[i])
            if (gap_q[i] != m_ilen) n++;
        return n;
    endfunction

    task automatic clear_mon();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
    endtask

    task automatic start_run(input int total, input int lc, input int ic, input bit en96);
        clear_mon();
        model_run(total, lc, ic, en96);
        @(negedge clk);
        rf_total_words     = 20'(total);
        rf_pkt_data_length = 2'(lc);
        rf_pkt_idle_length = 2'(ic);
        rf_96path_en       = en96;
        fast_read_en       = 1'b1;
        start_cyc          = cyc;
        @(negedge clk);
        fast_read_en = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit timed_out);
        int n = 0;
        while (done_cnt_a == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        timed_out = (done_cnt_a == 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ce_a !== '0 || addr_a !== '0) begin
            errors++; $display("FAIL reset_sram_if: chip_en=%h addr=%h, required 0/0", ce_a, addr_a);
        end
        checks++;
        if ({done_a, busy_a, vld_a} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: done/busy/valid=%b, required 000", {done_a, busy_a, vld_a});
        end
        checks++;
        if (data_a !== '0 || data_b !== '0) begin
            errors++; $display("FAIL reset_data: data_a=%h data_b=%h, required 0", data_a, data_b);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || ce_a !== '0) begin
            errors++; $display("FAIL idle_no_start: busy=%b chip_en=%h, required 0/0", busy_a, ce_a);
        end
    endtask

    task automatic test_basic_packets();
        bit to;
        start_run(200, 0, 0, 1'b1);
        wait_done(1000, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: done not seen, required one pulse"); end
        checks++; if (burst_mism() !== 0) begin
            errors++; $display("FAIL basic_bursts: got %0d bursts/%0d gaps, required %0d bursts with gap %0d", burst_q.size(), gap_q.size(), exp_burst.size(), m_ilen);
        end
        checks++; if (ce_mism() !== 0) begin
            errors++; $display("FAIL basic_bank_seq: %0d mismatches over %0d enables, required 0 over %0d", ce_mism(), ce_bank_q.size(), exp_bank.size());
        end
        checks++; if (done_cyc_a - last_ce_a !== 2) begin
            errors++; $display("FAIL basic_done_lat: done %0d cycles after last enable, required 2", done_cyc_a - last_ce_a);
        end
        checks++; if (first_ce_a - start_cyc !== 2) begin
            errors++; $display("FAIL basic_start_lat: first enable %0d cycles after start, required 2", first_ce_a - start_cyc);
        end
        checks++; if (first_vld_a - first_ce_a !== 2) begin
            errors++; $display("FAIL basic_data_lat1: valid %0d cycles after enable, required 2", first_vld_a - first_ce_a);
        end
        checks++; if (first_vld_b - first_ce_b !== 4) begin
            errors++; $display("FAIL basic_data_lat3: valid %0d cycles after enable, required 4", first_vld_b - first_ce_b);
        end
        checks++; if (data_mism(1'b0) !== 0 || data_mism(1'b1) !== 0) begin
            errors++; $display("FAIL basic_data: mismatches lat1=%0d lat3=%0d, required 0", data_mism(1'b0), data_mism(1'b1));
        end
        checks++; if (mh_a !== 0 || done_cnt_a !== 1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL basic_misc: multihot=%0d done_pulses=%0d busy=%b, required 0/1/0", mh_a, done_cnt_a, busy_a);
        end
    endtask

    task automatic test_half_banks();
        bit to;
        int max_bank = -1;
        int max_addr = -1;
        start_run(1536, 3, 3, 1'b0);
        wait_done(4000, to);
        foreach (ce_bank_q[i]) begin
            if (ce_bank_q[i] > max_bank) max_bank = ce_bank_q[i];
            if (ce_addr_q[i] > max_addr) max_addr = ce_addr_q[i];
        end
        checks++; if (to) begin errors++; $display("FAIL half_timeout: done not seen, required one pulse"); end
        checks++; if (burst_mism() !== 0) begin
            errors++; $display("FAIL half_bursts: got %0d bursts/%0d gaps, required %0d bursts with gap %0d", burst_q.size(), gap_q.size(), exp_burst.size(), m_ilen);
        end
        checks++; if (ce_mism() !== 0) begin
            errors++; $display("FAIL half_bank_seq: %0d mismatches over %0d enables, required 0", ce_mism(), ce_bank_q.size());
        end
        checks++; if (max_bank !== 11 || max_addr !== (1536 - 1) / 12) begin
            errors++; $display("FAIL half_range: max bank %0d addr %0d, required 11 and %0d", max_bank, max_addr, (1536 - 1) / 12);
        end
        checks++; if (data_mism(1'b1) !== 0) begin
            errors++; $display("FAIL half_data_lat3: %0d mismatches, required 0", data_mism(1'b1));
        end
    endtask

    task automatic test_zero_total();
        bit to;
        start_run(0, 1, 1, 1'b1);
        wait_done(20, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: done not seen, required one pulse"); end
        checks++; if (ce_bank_q.size() !== 0 || dq_a.size() !== 0) begin
            errors++; $display("FAIL zero_activity: %0d enables %0d words, required 0/0", ce_bank_q.size(), dq_a.size());
        end
        checks++; if (done_cyc_a - start_cyc !== 2 || done_cnt_a !== 1) begin
            errors++; $display("FAIL zero_done: done %0d cycles after start, %0d pulses, required 2 and 1", done_cyc_a - start_cyc, done_cnt_a);
        end
    endtask

    task automatic test_reset_midrun();
        bit to;
        int n = 0;
        int n0;
        start_run(200, 0, 0, 1'b1);
        while (ce_bank_q.size() < 50 && n < 200) begin @(negedge clk); n++; end
        checks++; if (ce_bank_q.size() < 50) begin
            errors++; $display("FAIL rstmid_reach: %0d enables seen, required 50", ce_bank_q.size());
        end
        rst = 1'b1;
        #1;
        n0 = ce_bank_q.size();
        checks++; if (ce_a !== '0 || addr_a !== '0 || {done_a, busy_a, vld_a} !== 3'b000 || data_a !== '0 || ce_b !== '0 || vld_b !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: ce=%h addr=%h flags=%b data=%h, required all 0", ce_a, addr_a, {done_a, busy_a, vld_a}, data_a);
        end
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (done_cnt_a !== 0 || done_cnt_b !== 0 || ce_bank_q.size() !== n0) begin
            errors++; $display("FAIL rstmid_quiet: done pulses %0d/%0d enables +%0d, required 0/0/+0", done_cnt_a, done_cnt_b, ce_bank_q.size() - n0);
        end
        start_run(100, 1, 2, 1'b1);
        wait_done(500, to);
        checks++; if (to || done_cnt_a !== 1) begin errors++; $display("FAIL rstmid_rerun_done: %0d pulses, required 1", done_cnt_a); end
        checks++; if (ce_mism() !== 0 || data_mism(1'b0) !== 0 || data_mism(1'b1) !== 0) begin
            errors++; $display("FAIL rstmid_rerun_seq: ce=%0d d1=%0d d3=%0d mismatches, required 0", ce_mism(), data_mism(1'b0), data_mism(1'b1));
        end
    endtask

    task automatic test_midrun_config();
        bit to;
        start_run(500, 0, 1, 1'b1);
        for (int i = 0; i < 150; i++) begin
            fast_read_en       = 1'($urandom);
            rf_pkt_data_length = 2'($urandom);
            rf_pkt_idle_length = 2'($urandom);
            rf_total_words     = 20'($urandom_range(0, 3000));
            rf_96path_en       = 1'($urandom);
            @(negedge clk);
        end
        fast_read_en = 1'b0;
        wait_done(1000, to);
        checks++; if (to || done_cnt_a !== 1) begin errors++; $display("FAIL midcfg_done: %0d pulses, required 1", done_cnt_a); end
        checks++; if (burst_mism() !== 0) begin
            errors++; $display("FAIL midcfg_bursts: got %0d bursts/%0d gaps, required %0d bursts with gap %0d", burst_q.size(), gap_q.size(), exp_burst.size(), m_ilen);
        end
        checks++; if (ce_mism() !== 0 || data_mism(1'b0) !== 0) begin
            errors++; $display("FAIL midcfg_seq: ce=%0d data=%0d mismatches, required 0", ce_mism(), data_mism(1'b0));
        end
    endtask

    task automatic test_random_runs();
        bit to;
        int total, lc, ic;
        bit en;
        for (int r = 0; r < 4; r++) begin
            total = int'($urandom_range(1, 700));
            lc    = int'($urandom_range(0, 2));
            ic    = int'($urandom_range(0, 3));
            en    = 1'($urandom_range(0, 1));
            start_run(total, lc, ic, en);
            wait_done(total + 400, to);
            checks++; if (to || done_cnt_a !== 1 || done_cnt_b !== 1) begin
                errors++; $display("FAIL rand%0d_done: pulses %0d/%0d, required 1/1", r, done_cnt_a, done_cnt_b);
            end
            checks++; if (ce_mism() !== 0 || mh_a !== 0) begin
                errors++; $display("FAIL rand%0d_ce: %0d mismatches %0d multihot (total=%0d en96=%0d), required 0/0", r, ce_mism(), mh_a, total, en);
            end
            checks++; if (burst_mism() !== 0) begin
                errors++; $display("FAIL rand%0d_bursts: got %0d bursts/%0d gaps, required %0d bursts with gap %0d", r, burst_q.size(), gap_q.size(), exp_burst.size(), m_ilen);
            end
            checks++; if (data_mism(1'b0) !== 0 || data_mism(1'b1) !== 0) begin
                errors++; $display("FAIL rand%0d_data: mismatches lat1=%0d lat3=%0d, required 0", r, data_mism(1'b0), data_mism(1'b1));
            end
            checks++; if (done_cyc_a - last_ce_a !== 2) begin
                errors++; $display("FAIL rand%0d_done_lat: %0d cycles, required 2", r, done_cyc_a - last_ce_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_packets();
        test_half_banks();
        test_zero_total();
        test_reset_midrun();
        test_midrun_config();
        test_random_runs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
